// File: rtl/fetch_stage.sv
// Instruction fetch stage: request/grant memory interface, in-order prefetch FIFO and redirect handling.
// Optional stall counter output enabled by defining FETCH_STALL_COUNT_EN.
module fetch_stage #(
    parameter int unsigned           WORD_WIDTH = 32,
    parameter logic [WORD_WIDTH-1:0] BOOT_ADDR  = '0,
    parameter int unsigned           FIFO_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  instr_req_o,
    output logic [WORD_WIDTH-1:0] instr_addr_o,
    input  logic                  instr_gnt_i,
    input  logic                  instr_rvalid_i,
    input  logic [WORD_WIDTH-1:0] instr_rdata_i,
    input  logic                  branch_pc_ctrl_i,
    input  logic [WORD_WIDTH-1:0] branch_target_i,
    output logic [WORD_WIDTH-1:0] instruction_o,
    output logic [WORD_WIDTH-1:0] pc_o,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i
`ifdef FETCH_STALL_COUNT_EN
    ,
    output logic [31:0]           stall_count_o
`endif
);

    localparam int unsigned           PTR_W      = (FIFO_DEPTH > 2) ? 2 : 1;
    localparam int unsigned           CNT_W      = 3;
    localparam logic [CNT_W:0]        DEPTH_C    = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]      LAST_PTR   = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [WORD_WIDTH-1:0] WORD_STEP  = WORD_WIDTH'(4);
    localparam logic [WORD_WIDTH-1:0] ALIGN_MASK = ~WORD_WIDTH'(3);

    logic [WORD_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
    logic [WORD_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic [CNT_W-1:0]      discard_q, discard_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [WORD_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [WORD_WIDTH-1:0] fifo_data_d [FIFO_DEPTH];
    logic [WORD_WIDTH-1:0] fifo_pc_q   [FIFO_DEPTH];
    logic [WORD_WIDTH-1:0] fifo_pc_d   [FIFO_DEPTH];

    logic fifo_empty, accept, rsp_valid, push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        fifo_empty    = (count_q == '0);
        instr_req_o   = !rst_i && !branch_pc_ctrl_i &&
                        (({1'b0, count_q} + {1'b0, outstanding_q}) < DEPTH_C);
        instr_addr_o  = fetch_addr_q;
        instr_valid_o = !fifo_empty && !branch_pc_ctrl_i;
        instruction_o = fifo_empty ? '0 : fifo_data_q[rd_ptr_q];
        pc_o          = fifo_empty ? '0 : fifo_pc_q[rd_ptr_q];
    end

    always_comb begin
        accept    = instr_req_o && instr_gnt_i;
        rsp_valid = instr_rvalid_i && (outstanding_q != '0);
        push      = rsp_valid && (discard_q == '0) && !branch_pc_ctrl_i;
        pop       = instr_valid_o && instr_ready_i;

        outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(rsp_valid);

        // On redirect everything still in flight after this cycle is stale; a response
        // returning in the redirect cycle itself is already excluded from that number.
        discard_d = discard_q;
        if (branch_pc_ctrl_i) begin
            discard_d = outstanding_d;
        end else if (rsp_valid && (discard_q != '0)) begin
            discard_d = discard_q - CNT_W'(1);
        end

        fetch_addr_d = fetch_addr_q;
        resp_pc_d    = resp_pc_q;
        if (branch_pc_ctrl_i) begin
            fetch_addr_d = branch_target_i & ALIGN_MASK;
            resp_pc_d    = branch_target_i & ALIGN_MASK;
        end else begin
            if (accept) fetch_addr_d = fetch_addr_q + WORD_STEP;
            if (push)   resp_pc_d    = resp_pc_q + WORD_STEP;
        end

        fifo_data_d = fifo_data_q;
        fifo_pc_d   = fifo_pc_q;
        if (push) begin
            fifo_data_d[wr_ptr_q] = instr_rdata_i;
            fifo_pc_d[wr_ptr_q]   = resp_pc_q;
        end

        if (branch_pc_ctrl_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
            rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_addr_q  <= BOOT_ADDR;
            resp_pc_q     <= BOOT_ADDR;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_addr_q  <= fetch_addr_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        fifo_data_q <= fifo_data_d;
        fifo_pc_q   <= fifo_pc_d;
    end

`ifdef FETCH_STALL_COUNT_EN
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (instr_ready_i && !instr_valid_o && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
        stall_count_o = stall_count_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) stall_count_q <= '0;
        else       stall_count_q <= stall_count_d;
    end
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(instr_rvalid_i && (outstanding_q == '0)))
                else $warning("fetch_stage: rvalid with no outstanding request ignored");
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic scored
// against a queue-based model of requests in flight and instructions buffered.
module tb_fetch_stage;

    localparam int unsigned DEPTH = 3;
    localparam logic [31:0] BOOT  = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i, gnt, rvalid, branch, ready;
    logic [31:0] rdata, target;
    logic        req, valid;
    logic [31:0] addr, instr, pc;
`ifdef FETCH_STALL_COUNT_EN
    logic [31:0] stall_count;
`endif

    always #5 clk_i = ~clk_i;

    fetch_stage #(
        .WORD_WIDTH (32),
        .BOOT_ADDR  (BOOT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .instr_req_o      (req),
        .instr_addr_o     (addr),
        .instr_gnt_i      (gnt),
        .instr_rvalid_i   (rvalid),
        .instr_rdata_i    (rdata),
        .branch_pc_ctrl_i (branch),
        .branch_target_i  (target),
        .instruction_o    (instr),
        .pc_o             (pc),
        .instr_valid_o    (valid),
        .instr_ready_i    (ready)
`ifdef FETCH_STALL_COUNT_EN
        ,
        .stall_count_o    (stall_count)
`endif
    );

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    logic [31:0] mem_q [$];   // addresses granted, response not yet returned
    logic [31:0] buf_q [$];   // addresses whose data is buffered for delivery
    logic [31:0] acc_log [$];
    logic [31:0] cons_pc [$];
    logic [31:0] cons_dat [$];
    int unsigned disc;
    logic [31:0] fetch_exp;
    int          acc_total, cons_total, cyc_since_rst, first_valid;
    logic [31:0] first_pc;
    bit          auto_mem, rand_mode;
    bit          pend_req;
    logic [31:0] pend_addr;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model();
        bit          consume;
        logic [31:0] a;
        if (rst_i) begin
            chk("req_in_reset", {31'b0, req}, 32'd0);
            mem_q.delete(); buf_q.delete(); acc_log.delete(); cons_pc.delete(); cons_dat.delete();
            disc = 0; fetch_exp = BOOT; acc_total = 0; cons_total = 0;
            cyc_since_rst = 0; first_valid = -1; pend_req = 0;
            return;
        end
        chk("req", {31'b0, req},
            {31'b0, (buf_q.size() + mem_q.size() < DEPTH) && !branch});
        chk("valid", {31'b0, valid}, {31'b0, (buf_q.size() > 0) && !branch});
        if (req) chk("addr", addr, fetch_exp);
        if (pend_req && !branch) begin
            chk("req_held", {31'b0, req}, 32'd1);
            chk("addr_held", addr, pend_addr);
        end
        if (valid && first_valid < 0) begin
            first_valid = cyc_since_rst;
            first_pc    = pc;
        end
        consume = valid && ready;
        if (consume) begin
            a = (buf_q.size() > 0) ? buf_q[0] : 32'hxxxx_xxxx;
            chk("pc", pc, a);
            chk("instr", instr, mem_fn(a));
            cons_pc.push_back(pc);
            cons_dat.push_back(instr);
            cons_total++;
            if (buf_q.size() > 0) void'(buf_q.pop_front());
        end
        if (rvalid && mem_q.size() > 0) begin
            a = mem_q.pop_front();
            if (disc > 0) disc--;
            else if (!branch) buf_q.push_back(a);
        end
        pend_req  = req && !gnt;
        pend_addr = addr;
        if (branch) begin
            buf_q.delete();
            fetch_exp = target & ~32'd3;
            disc      = mem_q.size();
        end else if (req && gnt) begin
            mem_q.push_back(addr);
            acc_log.push_back(addr);
            acc_total++;
            fetch_exp = fetch_exp + 32'd4;
        end
        cyc_since_rst++;
    endtask

    task automatic tick();
        if (auto_mem) begin
            gnt    = 1'b1;
            rvalid = (mem_q.size() > 0);
            rdata  = rvalid ? mem_fn(mem_q[0]) : 32'h0;
        end else if (rand_mode) begin
            gnt    = ($urandom_range(0, 3) != 0);
            rvalid = (mem_q.size() > 0) && ($urandom_range(0, 1) == 1);
            rdata  = rvalid ? mem_fn(mem_q[0]) : $urandom;
            ready  = ($urandom_range(0, 1) == 1);
            branch = ($urandom_range(0, 15) == 0);
            target = $urandom_range(0, 1023);
        end
        @(negedge clk_i);
        model();
        @(posedge clk_i);
        #1;
    endtask

    task automatic reset_dut();
        rst_i = 1'b1; auto_mem = 0; rand_mode = 0;
        gnt = 0; rvalid = 0; branch = 0; ready = 0;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic wait_consume(input string tag);
        for (int i = 0; i < 40 && cons_pc.size() == 0; i++) tick();
        if (cons_pc.size() == 0) chk(tag, 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1; gnt = 0; rvalid = 0; rdata = 0; branch = 0; target = 0; ready = 0;
        auto_mem = 0; rand_mode = 0;
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_req", {31'b0, req}, 32'd1);
        chk("rst_addr", addr, BOOT);

        // Reset release, grant always high, 1-cycle response latency
        ready = 1; auto_mem = 1;
        repeat (8) tick();
        for (int i = 0; i < 3; i++)
            chk($sformatf("a_addr%0d", i), (i < acc_log.size()) ? acc_log[i] : 32'hxxxx_xxxx,
                32'(i * 4));
        chk("a_first_valid_cycle", first_valid, 32'd2);
        chk("a_first_pc", first_pc, BOOT);

        // Downstream stalled: buffer fills to DEPTH, then drains without loss
        reset_dut();
        auto_mem = 1;
        repeat (10) tick();
        chk("b_req_low", {31'b0, req}, 32'd0);
        chk("b_valid", {31'b0, valid}, 32'd1);
        chk("b_buffered", acc_total - cons_total, DEPTH);
        chk("b_mem_idle", mem_q.size(), 32'd0);
        ready = 1;
        repeat (10) tick();
        for (int i = 0; i < DEPTH; i++)
            chk($sformatf("b_pc%0d", i), (i < cons_pc.size()) ? cons_pc[i] : 32'hxxxx_xxxx,
                32'(i * 4));

        // Redirect to an unaligned target with two requests outstanding
        reset_dut();
        gnt = 1;
        tick();
        tick();
        gnt = 0;
        chk("c_outstanding", mem_q.size(), 32'd2);
        branch = 1; target = 32'h103;
        #1;
        chk("c_req_redirect", {31'b0, req}, 32'd0);
        tick();
        branch = 0;
        #1;
        chk("c_addr", addr, 32'h100);
        acc_log.delete(); cons_pc.delete(); cons_dat.delete();
        auto_mem = 1; ready = 1;
        wait_consume("c_timeout");
        chk("c_first_acc", (acc_log.size() > 0) ? acc_log[0] : 32'hxxxx_xxxx, 32'h100);
        chk("c_first_pc", (cons_pc.size() > 0) ? cons_pc[0] : 32'hxxxx_xxxx, 32'h100);

        // Response arriving in the redirect cycle, with one instruction buffered
        reset_dut();
        gnt = 1;
        tick();
        rvalid = 1; rdata = mem_fn(32'h0);
        tick();
        gnt = 0; rvalid = 1; rdata = mem_fn(32'h4); branch = 1; target = 32'h200;
        #1;
        chk("d_valid_forced_low", {31'b0, valid}, 32'd0);
        tick();
        branch = 0; rvalid = 0;
        #1;
        chk("d_valid_after", {31'b0, valid}, 32'd0);
        chk("d_req", {31'b0, req}, 32'd1);
        chk("d_addr", addr, 32'h200);
        cons_pc.delete(); cons_dat.delete();
        auto_mem = 1; ready = 1;
        wait_consume("d_timeout");
        chk("d_first_pc", (cons_pc.size() > 0) ? cons_pc[0] : 32'hxxxx_xxxx, 32'h200);

        // One-cycle reset with a request outstanding; the late response is ignored
        reset_dut();
        gnt = 1;
        tick();
        gnt = 0; rst_i = 1;
        tick();
        rst_i = 0; rvalid = 1; rdata = 32'hDEAD_BEEF; gnt = 1;
        tick();
        rvalid = 0;
        #1;
        chk("e_valid", {31'b0, valid}, 32'd0);
        auto_mem = 1; ready = 1;
        wait_consume("e_timeout");
        chk("e_first_pc", (cons_pc.size() > 0) ? cons_pc[0] : 32'hxxxx_xxxx, BOOT);
        chk("e_first_instr", (cons_dat.size() > 0) ? cons_dat[0] : 32'hxxxx_xxxx, mem_fn(BOOT));

        // Randomized traffic against the model
        reset_dut();
        rand_mode = 1;
        repeat (800) tick();
        rand_mode = 0; branch = 0;

`ifdef FETCH_STALL_COUNT_EN
        reset_dut();
        ready = 1; gnt = 0;
        repeat (5) tick();
        chk("g_stall_count", stall_count, 32'd5);
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
